// File: rtl/ann_result_tx.sv
// ============================================================================
// Module   : ann_result_tx
// Brief    : Nibble-serial result transmitter. Queues result words in a small
//            FIFO and frames each one as header (4'hA), data nibbles
//            (MSB first) and an optional XOR checksum on a 4-bit pad bus.
//            The host paces the stream by toggling an acknowledge pin.
// Config   : define ANN_RESULT_TX_CHECKSUM_EN to append the checksum nibble.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ann_result_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic [DATA_W-1:0]             res_data_i,
  input  logic                          host_ack_i,
  output logic [3:0]                    tx_nibble_o,
  output logic [3:0]                    tx_oeb_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int NIB   = DATA_W / 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
  localparam logic [3:0]       HDR_NIB  = 4'hA;

`ifdef ANN_RESULT_TX_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Acknowledge synchronizer, history flop and post-reset arm counter
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              s3_q, s3_d;
  logic [1:0]        arm_q, arm_d;

  // Framer state
  state_t            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        nib_q, nib_d;
  logic [3:0]        oeb_q, oeb_d;
  logic              busy_q, busy_d;
`ifdef ANN_RESULT_TX_CHECKSUM_EN
  logic [3:0]        csum_q, csum_d;
`endif

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_seek;
  logic              w_ack_edge;
  logic [3:0]        w_top_nib;

  assign w_empty    = (level_q == '0);
  assign w_push     = res_valid_i && (level_q != DEPTH_L);
  assign w_ack_edge = (s2_q ^ s3_q) && (arm_q == 2'd3);
  assign w_top_nib  = sreg_q[DATA_W-1 -: 4];

  // Next-state logic for the synchronizer, FIFO and framer
  always_comb begin
    s1_d     = host_ack_i;
    s2_d     = s1_q;
    s3_d     = s2_q;
    arm_d    = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    oeb_d    = 4'h0;
    state_d  = state_q;
    sreg_d   = sreg_q;
    idx_d    = idx_q;
    nib_d    = nib_q;
`ifdef ANN_RESULT_TX_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    w_pop    = 1'b0;
    w_seek   = 1'b0;

    case (state_q)
      ST_IDLE: w_seek = 1'b1;
      ST_HDR: begin
        if (w_ack_edge) begin
          state_d = ST_DATA;
          idx_d   = '0;
          nib_d   = w_top_nib;
        end
      end
      ST_DATA: begin
        if (w_ack_edge) begin
          // Shift the acknowledged nibble out; the next one surfaces at the top
          sreg_d = sreg_q << 4;
`ifdef ANN_RESULT_TX_CHECKSUM_EN
          csum_d = csum_q ^ w_top_nib;
`endif
          if (idx_q == IDX_LAST) begin
`ifdef ANN_RESULT_TX_CHECKSUM_EN
            state_d = ST_CSUM;
            nib_d   = csum_q ^ w_top_nib;
`else
            w_seek  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
            nib_d = sreg_d[DATA_W-1 -: 4];
          end
        end
      end
`ifdef ANN_RESULT_TX_CHECKSUM_EN
      ST_CSUM: begin
        if (w_ack_edge) w_seek = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Start a frame from the FIFO head, or fall back to idle when empty
    if (w_seek) begin
      if (!w_empty) begin
        w_pop   = 1'b1;
        sreg_d  = mem_q[rd_ptr_q];
        state_d = ST_HDR;
        nib_d   = HDR_NIB;
`ifdef ANN_RESULT_TX_CHECKSUM_EN
        csum_d  = 4'h0;
`endif
      end else begin
        state_d = ST_IDLE;
        nib_d   = 4'h0;
      end
    end

    wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      arm_q    <= 2'd0;
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      idx_q    <= '0;
      nib_q    <= 4'h0;
      oeb_q    <= 4'hF;
      busy_q   <= 1'b0;
`ifdef ANN_RESULT_TX_CHECKSUM_EN
      csum_q   <= 4'h0;
`endif
    end else begin
      if (w_push) mem_q[wr_ptr_q] <= res_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      arm_q    <= arm_d;
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      idx_q    <= idx_d;
      nib_q    <= nib_d;
      oeb_q    <= oeb_d;
      busy_q   <= busy_d;
`ifdef ANN_RESULT_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign tx_nibble_o  = nib_q;
  assign tx_oeb_o     = oeb_q;
  assign busy_o       = busy_q;
  assign res_ready_o  = (level_q != DEPTH_L);
  assign fifo_level_o = level_q;

endmodule

`default_nettype wire
